display_scan: RTL and testbench
===============================

# display_scan

Time-multiplexed driver for the game's 8-digit, common-anode 7-segment display. It sits downstream of the 8-way nibble selector. It generates the selector's S2/S1/S0 lines and reads back the selected 4-bit value F. It decodes F to segments and drives one active-low anode at a time, with a dead-time blanking window between digits to prevent ghosting.

## Interface
- DIV, 50000: clock cycles per digit slot (1 kHz digit rate at 50 MHz); must satisfy DIV > BLANK_CYC.
- BLANK_CYC, 16: leading cycles of each slot with all anodes off; must be >= 2.
- CLK  input  1  rising-edge clock; the block uses one clock only.
- RESETN  input  1  asynchronous, active-low reset.
- EN  input  1  scan enable; low forces the display dark and restarts the scan.
- F  input  4  nibble returned by the selector for the current S2/S1/S0.
- BLANK_MASK  input  8  bit i = 1 keeps digit i dark.
- DP_MASK  input  8  bit i = 1 lights the decimal point on digit i.
- S2, S1, S0  output  1 each  selector controls for the current digit.
- AN  output  8  anode enables, active-low, one-hot-low when active.
- SEG  output  7  segments {g,f,e,d,c,b,a}, active-low.
- DP  output  1  decimal point, active-low.
- FRAME  output  1  one-cycle pulse at the start of slot 0.

## Operation
- State: slot counter cnt (0..DIV-1), digit index idx (0..7), latched nibble, latched mask bits. All outputs come straight from flops.
- Selector mapping: the selector returns W0–W3 when S2=1. Therefore S0=idx[0], S1=idx[1], S2=~idx[2], so digit n shows Wn.
- Each cycle with EN=1, cnt increments.
  - At cnt=DIV-1, cnt wraps to 0 and idx advances. 7 wraps to 0.
- Blank phase, cnt in [0, BLANK_CYC): AN=FF, SEG=7F, DP=1. S lines already reflect the new idx.
- Capture: on the edge ending cnt=BLANK_CYC-1, register F, BLANK_MASK[idx] and DP_MASK[idx]. Mask or F changes later in the slot are ignored.
- Active phase, cnt in [BLANK_CYC, DIV): SEG = hex decode of the captured nibble and AN[idx]=0.
  - If the captured blank bit is 1, AN stays FF and slot timing is unchanged.
  - DP=0 iff the captured DP bit is 1 and the digit is not blanked.
- Hex decode (active-low gfedcba) is a full 0–F table: 0→40, 1→79, 2→24, 3→30, 4→19, 5→12, 6→02, 7→78, 8→00, 9→10, A→08, b→03, C→46, d→21, E→06, F→0E.
- FRAME=1 exactly in the cycle where cnt=0 and idx=0 with EN=1.
- EN low: in the next cycle AN=FF, SEG=7F, DP=1, FRAME=0, cnt=0 and idx=0 (S=100), and the block holds there.
  - When EN returns high, that cycle is cnt=0 of slot 0 and FRAME pulses.

## Timing
- Reset values: cnt=0, idx=0, S2=1, S1=0, S0=0, AN=FF, SEG=7F, DP=1, FRAME=0. They apply immediately on RESETN low, independent of CLK.
- Reset release with EN=1: the first rising edge begins slot 0 at cnt=0 with FRAME=1.
- Reset mid-slot aborts the slot with no partial digit; on release the scan restarts at digit 0.
- Selector path: S settles at slot start and F is sampled BLANK_CYC-1 edges later, so the selector has at least one full cycle.
- Frame period = 8·DIV cycles. The active window is DIV−BLANK_CYC cycles per digit.
- No anode overlap: AN is FF for at least BLANK_CYC cycles between any two digits.

## Structure
- Shared package display_pkg holds:
  - NUM_DIGITS=8;
  - SEG_OFF=7'h7F and AN_OFF=8'hFF;
  - the 16-entry hex segment constants.
- Natural sub-module: hex_to_seg7, a combinational 4→7 active-low decoder, reused by other display paths.
- The counter, index and output registers stay in display_scan.

## Test plan
Sim parameters: DIV=8, BLANK_CYC=2; selector model Wn=n.
- Reset: hold RESETN low → AN=FF, SEG=7F, DP=1, {S2,S1,S0}=100, FRAME=0, asynchronously and before any clock.
- Scan order, EN=1 with masks 0:
  - AN walks FE,FD,FB,…,7F, each active 6 cycles after 2 blank cycles.
  - {S2,S1,S0} sequence is 100,101,110,111,000,001,010,011.
  - Digit 3 shows SEG=30 and digit 7 shows SEG=78.
  - FRAME pulses every 64 cycles.
- Blank mask: BLANK_MASK=04 → AN stays FF for the whole digit-2 slot; digit-3 activation time is unchanged.
- Decimal point and capture: DP_MASK=81 → DP=0 only in the active windows of digits 0 and 7. Toggling DP_MASK mid-active-window has no effect until the next slot.
- Enable drop: drop EN during digit 5's active window → next cycle AN=FF and S=100. Re-raise EN → FRAME=1 and digit 0 becomes active 2 cycles later.
- Decode sweep: force F through 0–F → SEG matches the Operation table for all 16 values; mid-slot reset → reset values, and the scan restarts at digit 0 after release.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display constants for the 7-segment display paths.
// - NUM_DIGITS : number of multiplexed digits
// - SEG_OFF    : all segments dark (active-low {g,f,e,d,c,b,a})
// - AN_OFF     : all anodes off (active-low)
// - HEX_SEG    : active-low segment patterns for hex digits 0..F
// - sel_of     : maps a digit index to the selector's {S2,S1,S0}
package display_pkg;

    localparam int         NUM_DIGITS = 8;
    localparam logic [6:0] SEG_OFF    = 7'h7F;
    localparam logic [7:0] AN_OFF     = 8'hFF;

    // Entry n is the pattern for nibble n (entry 0 is the rightmost element).
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
        7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
        7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
        7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
    };

    // The selector returns W0..W3 when S2=1, so S2 is the inverted MSB of
    // the digit index; digit n then shows word Wn.
    function automatic logic [2:0] sel_of(input logic [2:0] idx);
        return {~idx[2], idx[1:0]};
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex-to-7-segment decoder, active-low outputs.
// Ports:
//   hex : 4-bit nibble to display
//   seg : segments {g,f,e,d,c,b,a}, 0 = lit
module hex_to_seg7 (
    input  logic [3:0] hex,
    output logic [6:0] seg
);
    import display_pkg::*;

    always_comb begin
        seg = HEX_SEG[hex];
    end

endmodule

// File: rtl/display_scan.sv
// Time-multiplexed scanner for an 8-digit common-anode 7-segment display.
// Drives the nibble selector (S2/S1/S0), captures the returned nibble F
// once per digit slot, and lights one anode at a time with a blanking
// window at the start of every slot to prevent ghosting.
// Ports:
//   CLK, RESETN      : clock, asynchronous active-low reset
//   EN               : scan enable; low darkens the display and restarts the scan
//   F                : nibble returned by the selector
//   BLANK_MASK       : bit i = 1 keeps digit i dark
//   DP_MASK          : bit i = 1 lights the decimal point of digit i
//   S2, S1, S0       : selector controls for the current digit
//   AN               : anodes, active-low, one-hot-low while active
//   SEG, DP          : segments {g,f,e,d,c,b,a} and decimal point, active-low
//   FRAME            : one-cycle pulse at the start of slot 0
module display_scan #(
    parameter int DIV       = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       EN,
    input  logic [3:0] F,
    input  logic [7:0] BLANK_MASK,
    input  logic [7:0] DP_MASK,
    output logic       S2,
    output logic       S1,
    output logic       S0,
    output logic [7:0] AN,
    output logic [6:0] SEG,
    output logic       DP,
    output logic       FRAME
);
    import display_pkg::*;

    localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]   CAP_CNT  = CW'(BLANK_CYC - 1);
    localparam logic [CW-1:0]   ACT_CNT  = CW'(BLANK_CYC);

    // Scan state
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic          run_q, run_d;      // 0 = parked at slot 0 waiting for a start edge
    // Per-slot captured values
    logic [3:0]    nib_q, nib_d;
    logic          blank_q, blank_d;
    logic          dp_bit_q, dp_bit_d;
    // Output registers
    logic [2:0]    sel_q, sel_d;
    logic [7:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          frame_q, frame_d;

    logic          active_d;
    logic [6:0]    seg_dec;
    logic [7:0]    an_onehot;

    // Decode the nibble that will be held next cycle so SEG is registered
    // in the same edge that captures F.
    hex_to_seg7 u_hex_to_seg7 (
        .hex (nib_d),
        .seg (seg_dec)
    );

    // Active-low one-hot anode pattern for the next digit index.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_an
            assign an_onehot[gi] = (idx_d != 3'(gi));
        end
    endgenerate

    always_comb begin
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        run_d    = run_q;
        nib_d    = nib_q;
        blank_d  = blank_q;
        dp_bit_d = dp_bit_q;

        if (!EN) begin
            cnt_d = '0;
            idx_d = '0;
            run_d = 1'b0;
        end else if (!run_q) begin
            // First enabled edge after reset or EN low starts slot 0 at cnt=0.
            cnt_d = '0;
            idx_d = '0;
            run_d = 1'b1;
        end else begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                idx_d = idx_q + 3'd1;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
            // Sample at the end of the blank window: the selector has had
            // the whole window to settle, and later input changes are ignored.
            if (cnt_q == CAP_CNT) begin
                nib_d    = F;
                blank_d  = BLANK_MASK[idx_q];
                dp_bit_d = DP_MASK[idx_q];
            end
        end

        active_d = run_d && (cnt_d >= ACT_CNT);
        sel_d    = sel_of(idx_d);
        an_d     = (active_d && !blank_d) ? an_onehot : AN_OFF;
        seg_d    = active_d ? seg_dec : SEG_OFF;
        dp_d     = !(active_d && dp_bit_d && !blank_d);
        frame_d  = run_d && (cnt_d == '0) && (idx_d == '0);
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            cnt_q    <= '0;
            idx_q    <= '0;
            run_q    <= 1'b0;
            nib_q    <= '0;
            blank_q  <= 1'b0;
            dp_bit_q <= 1'b0;
            sel_q    <= 3'b100;
            an_q     <= AN_OFF;
            seg_q    <= SEG_OFF;
            dp_q     <= 1'b1;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            run_q    <= run_d;
            nib_q    <= nib_d;
            blank_q  <= blank_d;
            dp_bit_q <= dp_bit_d;
            sel_q    <= sel_d;
            an_q     <= an_d;
            seg_q    <= seg_d;
            dp_q     <= dp_d;
            frame_q  <= frame_d;
        end
    end

    assign S2    = sel_q[2];
    assign S1    = sel_q[1];
    assign S0    = sel_q[0];
    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DP    = dp_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_display_scan.sv
// Self-checking bench for display_scan with DIV=8, BLANK_CYC=2 and a
// selector model returning Wn=n. A frame-time reference model predicts
// every output each cycle; scenario tasks add targeted checks.
module tb_display_scan;

    localparam int DIV       = 8;
    localparam int BLANK     = 2;
    localparam int FRAME_LEN = 8 * DIV;

    logic       CLK        = 1'b0;
    logic       RESETN     = 1'b1;
    logic       EN         = 1'b0;
    logic [3:0] F;
    logic [7:0] BLANK_MASK = 8'h00;
    logic [7:0] DP_MASK    = 8'h00;
    logic       S2, S1, S0;
    logic [7:0] AN;
    logic [6:0] SEG;
    logic       DP;
    logic       FRAME;

    logic       force_en  = 1'b0;
    logic [3:0] force_val = 4'h0;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [2:0] s_seq [8] = '{3'b100, 3'b101, 3'b110, 3'b111, 3'b000, 3'b001, 3'b010, 3'b011};

    always #5 CLK = ~CLK;

    // Selector: digit n = {~S2,S1,S0} returns word n, unless a nibble is forced.
    assign F = force_en ? force_val : {1'b0, ~S2, S1, S0};

    display_scan #(.DIV(DIV), .BLANK_CYC(BLANK)) dut (
        .CLK(CLK), .RESETN(RESETN), .EN(EN), .F(F),
        .BLANK_MASK(BLANK_MASK), .DP_MASK(DP_MASK),
        .S2(S2), .S1(S1), .S0(S0), .AN(AN), .SEG(SEG), .DP(DP), .FRAME(FRAME)
    );

    logic [19:0] dut_vec;
    assign dut_vec = {AN, SEG, DP, FRAME, S2, S1, S0};

    // Reference model: time m_t within the frame, plus values captured per slot.
    logic       m_run;
    int         m_t;
    logic [3:0] m_nib;
    logic       m_blank, m_dp;

    always @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            m_run <= 1'b0;
            m_t   <= 0;
        end else if (!EN) begin
            m_run <= 1'b0;
            m_t   <= 0;
        end else if (!m_run) begin
            m_run <= 1'b1;
            m_t   <= 0;
        end else begin
            if (m_t % DIV == BLANK - 1) begin
                m_nib   <= force_en ? force_val : 4'(m_t / DIV);
                m_blank <= BLANK_MASK[m_t / DIV];
                m_dp    <= DP_MASK[m_t / DIV];
            end
            m_t <= (m_t + 1) % FRAME_LEN;
        end
    end

    function automatic logic [19:0] exp_vec();
        logic [7:0] an  = 8'hFF;
        logic [6:0] seg = 7'h7F;
        logic       dp  = 1'b1;
        logic       fr  = 1'b0;
        logic [2:0] s   = 3'b100;
        logic [2:0] d   = 3'(m_t / DIV);
        if (m_run) begin
            s  = s_seq[d];
            fr = (m_t == 0);
            if (m_t % DIV >= BLANK) begin
                seg = seg_tbl[m_nib];
                if (!m_blank) an = ~(8'h01 << d);
                dp = !(m_dp && !m_blank);
            end
        end
        return {an, seg, dp, fr, s};
    endfunction

    task automatic test_reset();
        #1 RESETN = 1'b0;
        #2;  // before the first rising clock edge
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL reset_an dut=%h exp=ff", AN); end
        checks++; if (SEG !== 7'h7F) begin errors++; $display("FAIL reset_seg dut=%h exp=7f", SEG); end
        checks++; if (DP !== 1'b1) begin errors++; $display("FAIL reset_dp dut=%b exp=1", DP); end
        checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL reset_frame dut=%b exp=0", FRAME); end
        checks++; if ({S2, S1, S0} !== 3'b100) begin errors++; $display("FAIL reset_sel dut=%b exp=100", {S2, S1, S0}); end
        repeat (2) @(negedge CLK);
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL reset_hold dut=%h exp=%h", dut_vec, exp_vec()); end
    endtask

    task automatic test_scan();
        int frame_last = -1;
        EN = 1'b1;
        RESETN = 1'b1;
        for (int k = 0; k < 2 * FRAME_LEN + 4; k++) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL scan k=%0d dut=%h exp=%h", k, dut_vec, exp_vec()); end
            if (k == 0) begin
                checks++; if (FRAME !== 1'b1) begin errors++; $display("FAIL scan_first_frame dut=%b exp=1", FRAME); end
            end
            if (k < FRAME_LEN && k % DIV == 0) begin
                checks++; if ({S2, S1, S0} !== s_seq[k / DIV]) begin errors++; $display("FAIL scan_sel k=%0d dut=%b exp=%b", k, {S2, S1, S0}, s_seq[k / DIV]); end
            end
            if (k < FRAME_LEN && k % DIV == BLANK) begin
                checks++; if (AN !== ~(8'h01 << (k / DIV))) begin errors++; $display("FAIL scan_an k=%0d dut=%h exp=%h", k, AN, ~(8'h01 << (k / DIV))); end
            end
            if (k == 3 * DIV + BLANK) begin
                checks++; if (SEG !== 7'h30) begin errors++; $display("FAIL scan_digit3 dut=%h exp=30", SEG); end
            end
            if (k == 7 * DIV + BLANK) begin
                checks++; if (SEG !== 7'h78) begin errors++; $display("FAIL scan_digit7 dut=%h exp=78", SEG); end
            end
            if (FRAME === 1'b1) begin
                if (frame_last >= 0) begin
                    checks++; if (k - frame_last != FRAME_LEN) begin errors++; $display("FAIL scan_frame_period dut=%0d exp=%0d", k - frame_last, FRAME_LEN); end
                end
                frame_last = k;
            end
        end
    endtask

    task automatic test_blank_mask();
        int first_f7 = -1;
        BLANK_MASK = 8'h04;
        EN = 1'b0;
        @(negedge CLK);
        checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL blank_idle dut=%h exp=%h", dut_vec, exp_vec()); end
        EN = 1'b1;
        for (int k = 0; k < FRAME_LEN; k++) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL blank k=%0d dut=%h exp=%h", k, dut_vec, exp_vec()); end
            if (k >= 2 * DIV && k < 3 * DIV) begin
                checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL blank_digit2 k=%0d dut=%h exp=ff", k, AN); end
            end
            if (AN === 8'hF7 && first_f7 < 0) first_f7 = k;
        end
        checks++; if (first_f7 != 3 * DIV + BLANK) begin errors++; $display("FAIL blank_digit3_time dut=%0d exp=%0d", first_f7, 3 * DIV + BLANK); end
        BLANK_MASK = 8'h00;
    endtask

    task automatic test_dp_capture();
        DP_MASK = 8'h81;
        for (int k = 0; k < 2 * FRAME_LEN; k++) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL dp k=%0d dut=%h exp=%h", k, dut_vec, exp_vec()); end
            if (DP === 1'b0) begin
                checks++; if (AN !== 8'hFE && AN !== 8'h7F) begin errors++; $display("FAIL dp_digit dut_an=%h exp=fe_or_7f", AN); end
            end
            // Scramble the mask mid-active-window; restore it before the next capture.
            if (m_t % DIV >= BLANK + 1) DP_MASK = 8'($urandom);
            else if (m_t % DIV == 0) DP_MASK = 8'h81;
        end
        DP_MASK = 8'h00;
    endtask

    task automatic test_random();
        int off = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL random k=%0d dut=%h exp=%h", k, dut_vec, exp_vec()); end
            if ($urandom_range(0, 3) == 0) BLANK_MASK = 8'($urandom);
            if ($urandom_range(0, 3) == 0) DP_MASK = 8'($urandom);
            if (off > 0) begin
                off--;
                if (off == 0) EN = 1'b1;
            end else if ($urandom_range(0, 39) == 0) begin
                EN = 1'b0;
                off = $urandom_range(1, 3);
            end
        end
        EN = 1'b1;
        BLANK_MASK = 8'h00;
        DP_MASK = 8'h00;
    endtask

    task automatic test_enable();
        int guard = 0;
        while (!(m_run && m_t == 5 * DIV + 4) && guard < 200) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 200) begin checks++; errors++; $display("FAIL enable_wait dut=timeout exp=digit5"); end
        EN = 1'b0;
        @(negedge CLK);
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL enable_drop_an dut=%h exp=ff", AN); end
        checks++; if ({S2, S1, S0} !== 3'b100) begin errors++; $display("FAIL enable_drop_sel dut=%b exp=100", {S2, S1, S0}); end
        checks++; if (FRAME !== 1'b0) begin errors++; $display("FAIL enable_drop_frame dut=%b exp=0", FRAME); end
        repeat (3) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL enable_hold dut=%h exp=%h", dut_vec, exp_vec()); end
        end
        EN = 1'b1;
        @(negedge CLK);
        checks++; if (FRAME !== 1'b1) begin errors++; $display("FAIL enable_frame dut=%b exp=1", FRAME); end
        @(negedge CLK);
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL enable_blank dut=%h exp=ff", AN); end
        @(negedge CLK);
        checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL enable_digit0 dut=%h exp=fe", AN); end
    endtask

    task automatic test_decode_sweep();
        int guard = 0;
        force_en = 1'b1;
        while (!(m_run && m_t % DIV == 0) && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 50) begin checks++; errors++; $display("FAIL decode_wait dut=timeout exp=slot_start"); end
        for (int v = 0; v < 16; v++) begin
            force_val = 4'(v);
            for (int k = 0; k < DIV; k++) begin
                @(negedge CLK);
                checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL decode v=%0d k=%0d dut=%h exp=%h", v, k, dut_vec, exp_vec()); end
                if (k == BLANK) begin
                    checks++; if (SEG !== seg_tbl[v]) begin errors++; $display("FAIL decode_seg v=%h dut=%h exp=%h", v, SEG, seg_tbl[v]); end
                end
            end
        end
        force_en = 1'b0;
        // Reset in the middle of an active window.
        guard = 0;
        while (!(m_run && m_t % DIV == 4) && guard < 50) begin
            @(negedge CLK);
            guard++;
        end
        if (guard >= 50) begin checks++; errors++; $display("FAIL midreset_wait dut=timeout exp=active"); end
        RESETN = 1'b0;
        #1;
        checks++; if (AN !== 8'hFF) begin errors++; $display("FAIL midreset_an dut=%h exp=ff", AN); end
        checks++; if (SEG !== 7'h7F) begin errors++; $display("FAIL midreset_seg dut=%h exp=7f", SEG); end
        checks++; if ({S2, S1, S0, DP, FRAME} !== 5'b10010) begin errors++; $display("FAIL midreset_ctl dut=%b exp=10010", {S2, S1, S0, DP, FRAME}); end
        repeat (2) @(negedge CLK);
        RESETN = 1'b1;
        for (int k = 0; k < 3 * DIV; k++) begin
            @(negedge CLK);
            checks++; if (dut_vec !== exp_vec()) begin errors++; $display("FAIL midreset_scan k=%0d dut=%h exp=%h", k, dut_vec, exp_vec()); end
            if (k == 0) begin
                checks++; if (FRAME !== 1'b1) begin errors++; $display("FAIL midreset_frame dut=%b exp=1", FRAME); end
            end
            if (k == BLANK) begin
                checks++; if (AN !== 8'hFE) begin errors++; $display("FAIL midreset_digit0 dut=%h exp=fe", AN); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_blank_mask();
        test_dp_capture();
        test_random();
        test_enable();
        test_decode_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
